fare_bcd_conv: RTL and testbench



---
 rtl/taxi_pkg.sv | 27 ++
 rtl/bcd_add3.sv | 19 +
 rtl/fare_bcd_conv.sv | 151 +++++++++++++++
 tb/tb_fare_bcd_conv.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// ============================================================================
// Module  : taxi_pkg
// Brief   : Shared constants and types for the taximeter BCD conversion path.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package taxi_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;
    localparam int MAX_DISP   = 999999;

    // Non-decimal code that the 7-segment decoder renders dark
    localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_CONV = 1'b1;

    typedef enum logic [0:0] {
        IDLE = c_ST_IDLE,
        CONV = c_ST_CONV
    } conv_state_t;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module  : bcd_add3
// Brief   : Double-dabble digit correction cell: adds 3 when the digit is >= 5.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import taxi_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= DIGIT_W'(5)) ? (i_digit + DIGIT_W'(3)) : i_digit;

endmodule

`default_nettype wire

// File: rtl/fare_bcd_conv.sv
// ============================================================================
// Module  : fare_bcd_conv
// Brief   : Sequential binary-to-BCD converter (one bit per clock) feeding the
//           taximeter 7-segment scan driver, with optional leading-zero blanking.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module fare_bcd_conv
    import taxi_pkg::*;
#(
    parameter int BIN_W    = 20,
    parameter int DIGITS   = NUM_DIGITS,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [DIGIT_W-1:0] one,
    output logic [DIGIT_W-1:0] ten,
    output logic [DIGIT_W-1:0] baek,
    output logic [DIGIT_W-1:0] cheon,
    output logic [DIGIT_W-1:0] man,
    output logic [DIGIT_W-1:0] sibman
);

    localparam int c_SCR_W = DIGIT_W * DIGITS;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int c_CMP_W = (BIN_W > 20) ? BIN_W : 20;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W - 1);
    localparam logic [c_CMP_W-1:0] c_MAX      = c_CMP_W'(MAX_DISP);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic [BIN_W-1:0]   r_shift;
    logic [c_SCR_W-1:0] r_scr;
    logic [c_SCR_W-1:0] w_scr_corr;
    logic [c_SCR_W-1:0] w_scr_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf_pend;
    logic               r_done;
    logic               r_ovf;
    logic               w_lead;
    logic [DIGIT_W-1:0] r_digit [DIGITS];
    logic [DIGIT_W-1:0] w_digit [DIGITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (r_cnt == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_scr[d*DIGIT_W +: DIGIT_W]),
                .o_digit (w_scr_corr[d*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Carry out of the top digit is discarded; overflow comes from the binary compare
    assign w_scr_nxt = (w_scr_corr << 1) | c_SCR_W'(r_shift[BIN_W-1]);

    always_comb begin
        w_lead = 1'b1;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            w_digit[d] = r_ovf_pend ? DIGIT_W'(9) : w_scr_nxt[d*DIGIT_W +: DIGIT_W];
            if (BLANK_LZ && (d != 0) && w_lead && (w_digit[d] == '0)) begin
                w_digit[d] = BCD_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            for (int d = 0; d < DIGITS; d++) begin
                r_digit[d] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_shift    <= bin;
                r_scr      <= '0;
                r_cnt      <= c_CNT_LAST;
                r_ovf_pend <= (c_CMP_W'(bin) > c_MAX);
            end else if (r_state == CONV) begin
                r_shift <= r_shift << 1;
                r_scr   <= w_scr_nxt;
                r_cnt   <= r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                    r_ovf  <= r_ovf_pend;
                    for (int d = 0; d < DIGITS; d++) begin
                        r_digit[d] <= w_digit[d];
                    end
                end
            end
        end
    end

    assign busy   = (r_state == CONV);
    assign done   = r_done;
    assign ovf    = r_ovf;
    assign one    = r_digit[0];
    assign ten    = r_digit[1];
    assign baek   = r_digit[2];
    assign cheon  = r_digit[3];
    assign man    = r_digit[4];
    assign sibman = r_digit[5];

endmodule

`default_nettype wire

// File: tb/tb_fare_bcd_conv.sv
// ============================================================================
// Module  : tb_fare_bcd_conv
// Brief   : Directed self-checking bench for fare_bcd_conv (plain and blanking).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fare_bcd_conv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] bin;

    logic        busy_a, done_a, ovf_a;
    logic [3:0]  a0, a1, a2, a3, a4, a5;
    logic        busy_b, done_b, ovf_b;
    logic [3:0]  b0, b1, b2, b3, b4, b5;
    logic [23:0] disp_a, disp_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fare_bcd_conv #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1'b0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_a), .done(done_a), .ovf(ovf_a),
        .one(a0), .ten(a1), .baek(a2), .cheon(a3), .man(a4), .sibman(a5)
    );

    fare_bcd_conv #(.BIN_W(20), .DIGITS(6), .BLANK_LZ(1'b1)) u_dut_blk (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy_b), .done(done_b), .ovf(ovf_b),
        .one(b0), .ten(b1), .baek(b2), .cheon(b3), .man(b4), .sibman(b5)
    );

    assign disp_a = {a5, a4, a3, a2, a1, a0};
    assign disp_b = {b5, b4, b3, b2, b1, b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses start for one edge; returns at the negedge following the accepting edge
    task automatic start_conv(input logic [19:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 20'hABCDE;
    endtask

    task automatic wait_done(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_a) begin
                chk("busy_with_done", {31'd0, busy_a}, 32'd0);
                chk("done_blk_sync", {31'd0, done_b}, 32'd1);
                break;
            end
            if (busy_a) busy_n++;
            if (n >= 60) begin
                chk("done_timeout", {31'd0, done_a}, 32'd1);
                break;
            end
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_a || done_b) cnt++;
        end
    endtask

    task automatic do_conv(input string tag, input logic [19:0] v,
                           input logic [23:0] exp_a, input logic [23:0] exp_b,
                           input logic exp_ovf);
        int n, bn;
        start_conv(v);
        wait_done(n, bn);
        chk({tag, "_lat"}, n, 20);
        chk({tag, "_dig"}, {8'd0, disp_a}, {8'd0, exp_a});
        chk({tag, "_blk"}, {8'd0, disp_b}, {8'd0, exp_b});
        chk({tag, "_ovf"}, {31'd0, ovf_a}, {31'd0, exp_ovf});
    endtask

    initial begin
        int n, bn, cnt;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("rst_dig", {8'd0, disp_a}, 32'd0);
        chk("rst_dig_blk", {8'd0, disp_b}, 32'd0);
        rst = 1'b0;

        start_conv(20'd123456);
        wait_done(n, bn);
        chk("c123456_lat", n, 20);
        chk("c123456_busy_cycles", bn, 19);
        chk("c123456_dig", {8'd0, disp_a}, 32'h123456);
        chk("c123456_blk", {8'd0, disp_b}, 32'h123456);
        chk("c123456_ovf", {31'd0, ovf_a}, 32'd0);

        do_conv("zero",    20'd0,       24'h000000, 24'hFFFFF0, 1'b0);
        do_conv("c4050",   20'd4050,    24'h004050, 24'hFF4050, 1'b0);
        do_conv("c999999", 20'd999999,  24'h999999, 24'h999999, 1'b0);
        do_conv("c1000000",20'd1000000, 24'h999999, 24'h999999, 1'b1);
        do_conv("c7",      20'd7,       24'h000007, 24'hFFFFF7, 1'b0);

        // Start during busy must be ignored
        start_conv(20'd500);
        repeat (3) @(negedge clk);
        start = 1'b1;
        bin   = 20'd77;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bn);
        chk("ign_lat", n, 16);
        chk("ign_dig", {8'd0, disp_a}, 32'h000500);
        chk("ign_blk", {8'd0, disp_b}, 32'hFFF500);
        count_dones(30, cnt);
        chk("ign_extra_done", cnt, 0);

        // Back-to-back: start asserted during the done cycle
        start_conv(20'd42);
        wait_done(n, bn);
        chk("b2b_first_dig", {8'd0, disp_a}, 32'h000042);
        chk("b2b_first_blk", {8'd0, disp_b}, 32'hFFFF42);
        start = 1'b1;
        bin   = 20'd31415;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy_a}, 32'd1);
        chk("b2b_done_low", {31'd0, done_a}, 32'd0);
        wait_done(n, bn);
        chk("b2b_gap", n + 1, 21);
        chk("b2b_second_dig", {8'd0, disp_a}, 32'h031415);
        chk("b2b_second_blk", {8'd0, disp_b}, 32'hF31415);

        do_conv("cmax", 20'hFFFFF, 24'h999999, 24'h999999, 1'b1);

        // Reset partway through a conversion
        start_conv(20'd123);
        repeat (8) @(negedge clk);
        chk("mid_busy_pre", {31'd0, busy_a}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("mid_rst_dig", {8'd0, disp_a}, 32'd0);
        chk("mid_rst_blk", {8'd0, disp_b}, 32'd0);
        rst = 1'b0;
        count_dones(30, cnt);
        chk("mid_rst_no_done", cnt, 0);
        chk("mid_rst_idle", {31'd0, busy_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
